// File: rtl/alu_exec_mc.sv
// alu_exec_mc: multi-cycle execute block (register file, operand-2 mux,
// single-cycle ALU, iterative shift-add multiplier).
// Build option: define ALU_EXEC_DIV_EN to add the restoring unsigned divider
// (ALUctrl 11 DIVU / 12 REMU). Without it, those codes return 0 in one cycle.
module alu_exec_mc #(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH          = 32,
  parameter int A0_INDEX            = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           ready,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
  input  logic                           WE3,
  input  logic                           ALUsrc,
  input  logic [3:0]                     ALUctrl,
  input  logic [DATA_WIDTH-1:0]          ImmOp,
  output logic                           EQ,
  output logic [DATA_WIDTH-1:0]          result,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int NREGS = 1 << REG_FILE_ADDR_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(DATA_WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

`ifdef ALU_EXEC_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL_RUN} state_t;
`endif

  state_t state, state_d;

  logic [DATA_WIDTH-1:0]          regs [NREGS];
  logic [DATA_WIDTH-1:0]          rd1, rd2, op2, alu_y;
  logic [SHW-1:0]                 shamt;
  logic                           accept, fin, wb_en;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]          wb_data;

  // Iteration context latched on accept of a multi-cycle op
  logic [REG_FILE_ADDR_WIDTH-1:0] ad3_q;
  logic                           we3_q;
  logic [SHW-1:0]                 cnt;
  logic [DATA_WIDTH-1:0]          mcand, mplier, acc, acc_d;

`ifdef ALU_EXEC_DIV_EN
  logic [DATA_WIDTH-1:0]          quo, dvsr, rem, quo_d, rem_d;
  logic [DATA_WIDTH:0]            rem_sh;
  logic                           rem_ge, rem_sel;
`endif

  // Register 0 is never written, so it always reads as zero.
  assign rd1    = regs[AD1];
  assign rd2    = regs[AD2];
  assign a0     = regs[A0_INDEX];
  assign op2    = ALUsrc ? ImmOp : rd2;
  assign shamt  = op2[SHW-1:0];
  assign ready  = (state == IDLE);
  assign accept = valid_in && ready;

  // One shift-add step: the value acc takes after this cycle
  assign acc_d = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_EXEC_DIV_EN
  // One restoring-division step; divisor 0 naturally yields q=all ones, r=dividend
  assign rem_sh = {rem, quo[DATA_WIDTH-1]};
  assign rem_ge = (rem_sh >= {1'b0, dvsr});
  assign rem_d  = rem_ge ? DATA_WIDTH'(rem_sh - {1'b0, dvsr}) : rem_sh[DATA_WIDTH-1:0];
  assign quo_d  = {quo[DATA_WIDTH-2:0], rem_ge};
`endif

  // Single-cycle ALU result
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    alu_y = '0;
    case (ALUctrl)
      OP_ADD:  alu_y = rd1 + op2;
      OP_SUB:  alu_y = rd1 - op2;
      OP_AND:  alu_y = rd1 & op2;
      OP_OR:   alu_y = rd1 | op2;
      OP_XOR:  alu_y = rd1 ^ op2;
      OP_SLL:  alu_y = rd1 << shamt;
      OP_SRL:  alu_y = rd1 >> shamt;
      OP_SRA:  alu_y = $signed(rd1) >>> shamt;
      OP_SLT:  alu_y = {{(DATA_WIDTH-1){1'b0}}, ($signed(rd1) < $signed(op2))};
      OP_SLTU: alu_y = {{(DATA_WIDTH-1){1'b0}}, (rd1 < op2)};
      default: alu_y = '0;
    endcase
  end

  // Next state and writeback selection
  always_comb begin
    state_d = state;
    fin     = 1'b0;
    wb_en   = 1'b0;
    wb_addr = AD3;
    wb_data = alu_y;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ALUctrl == OP_MUL) begin
            state_d = MUL_RUN;
`ifdef ALU_EXEC_DIV_EN
          end else if (ALUctrl == OP_DIVU || ALUctrl == OP_REMU) begin
            state_d = DIV_RUN;
`endif
          end else begin
            fin   = 1'b1;
            wb_en = WE3;
          end
        end
      end
      MUL_RUN: begin
        wb_addr = ad3_q;
        wb_data = acc_d;
        if (cnt == CNT_LAST) begin
          fin     = 1'b1;
          wb_en   = we3_q;
          state_d = IDLE;
        end
      end
`ifdef ALU_EXEC_DIV_EN
      DIV_RUN: begin
        wb_addr = ad3_q;
        wb_data = rem_sel ? rem_d : quo_d;
        if (cnt == CNT_LAST) begin
          fin     = 1'b1;
          wb_en   = we3_q;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Register file write port
  always_ff @(posedge clk) begin
    // NOTE: the register file is cleared on reset, so it is built from flops, not a RAM macro.
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Output flags, result and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      EQ     <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ad3_q  <= '0;
      we3_q  <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
`ifdef ALU_EXEC_DIV_EN
      quo     <= '0;
      dvsr    <= '0;
      rem     <= '0;
      rem_sel <= 1'b0;
`endif
    end else begin
      done <= fin;
      if (fin) result <= wb_data;
      if (accept) begin
        EQ     <= (rd1 == op2);
        ad3_q  <= AD3;
        we3_q  <= WE3;
        cnt    <= '0;
        mcand  <= rd1;
        mplier <= op2;
        acc    <= '0;
`ifdef ALU_EXEC_DIV_EN
        quo     <= rd1;
        dvsr    <= op2;
        rem     <= '0;
        rem_sel <= (ALUctrl == OP_REMU);
`endif
      end else if (state == MUL_RUN) begin
        cnt    <= cnt + 1'b1;
        acc    <= acc_d;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
`ifdef ALU_EXEC_DIV_EN
      else if (state == DIV_RUN) begin
        cnt <= cnt + 1'b1;
        quo <= quo_d;
        rem <= rem_d;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: scoreboard bench for alu_exec_mc (default parameters).
// Honours ALU_EXEC_DIV_EN the same way as the design.
module tb_alu_exec_mc;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, valid_in, ready, WE3, ALUsrc, EQ, done;
  logic [AW-1:0] AD1, AD2, AD3;
  logic [3:0]    ALUctrl;
  logic [DW-1:0] ImmOp, result, a0;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] mregs [32];

  always #5 clk = ~clk;

  alu_exec_mc #(.REG_FILE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .A0_INDEX(10)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(ready),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ImmOp(ImmOp), .EQ(EQ), .result(result),
    .done(done), .a0(a0)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $signed(a) >>> b[4:0];
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return a * b;
`ifdef ALU_EXEC_DIV_EN
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  // Issue one op once the block is ready; expected result goes to the scoreboard.
  task automatic op(input logic [3:0] c, input int a1, input int a2, input int a3,
                    input logic we, input logic src, input logic [DW-1:0] imm);
    logic [DW-1:0] x, y, r;
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    ALUctrl = c; AD1 = AW'(a1); AD2 = AW'(a2); AD3 = AW'(a3);
    WE3 = we; ALUsrc = src; ImmOp = imm; valid_in = 1'b1;
    x = mregs[a1];
    y = src ? imm : mregs[a2];
    r = model(c, x, y);
    sb.push_back(r);
    if (we && a3 != 0) mregs[a3] = r;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("eq", EQ, (x == y) ? 32'd1 : 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) check("done_extra", 32'd1, 32'd0);
        else                check("res", result, sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; valid_in = 1'b0; AD1 = '0; AD2 = '0; AD3 = '0;
    WE3 = 1'b0; ALUsrc = 1'b0; ALUctrl = '0; ImmOp = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_eq", EQ, 0);
    check("rst_result", result, 0);
    check("rst_a0", a0, 0);
    rst = 1'b0;

    // ADDI into a0
    op(4'd0, 0, 0, 10, 1, 1, 32'd5);
    check("a0_addi", a0, 32'd5);

    // Back-to-back ops and x0 protection
    op(4'd0, 0, 0, 1, 1, 1, 32'd7);
    op(4'd0, 0, 0, 2, 1, 1, 32'd7);
    op(4'd1, 1, 2, 3, 1, 0, 32'd0);
    op(4'd8, 3, 1, 4, 1, 0, 32'd0);
    op(4'd0, 0, 0, 0, 1, 1, 32'd9);
    op(4'd0, 0, 0, 6, 1, 1, 32'd0);
    op(4'd0, 4, 0, 7, 1, 1, 32'd0);
    op(4'd2, 1, 0, 8, 1, 1, 32'h5);
    op(4'd3, 1, 0, 8, 1, 1, 32'h18);
    op(4'd4, 1, 0, 8, 1, 1, 32'hF);
    op(4'd9, 1, 0, 8, 1, 1, 32'hFFFF_FFFF);
    op(4'd8, 1, 0, 8, 1, 1, 32'hFFFF_FFFF);
    op(4'd13, 1, 2, 8, 1, 0, 32'd0);
    op(4'd15, 1, 2, 8, 1, 0, 32'd0);
    op(4'd1, 0, 0, 13, 1, 1, 32'd1);
    drain();

    // MUL with busy-time request that must be ignored
    op(4'd0, 0, 0, 1, 1, 1, 32'hFFFF_FFFF);
    op(4'd0, 0, 0, 2, 1, 1, 32'd3);
    op(4'd10, 1, 2, 10, 1, 0, 32'd0);
    n = 0;
    while (!ready && n < 100) begin
      if (n == 3) begin
        ALUctrl = 4'd0; AD3 = 5'd5; WE3 = 1'b1; ALUsrc = 1'b1; ImmOp = 32'd77; valid_in = 1'b1;
      end
      if (n == 8) valid_in = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    check("mul_busy", n, 32);
    check("a0_mul", a0, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    op(4'd0, 5, 0, 9, 1, 1, 32'd0);
    op(4'd0, 0, 0, 2, 1, 1, 32'd12345);
    op(4'd10, 2, 0, 12, 1, 1, 32'd678);
    drain();

    // Reset in the middle of a MUL
    op(4'd10, 1, 2, 10, 1, 0, 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_ready", ready, 1);
    check("mrst_done", done, 0);
    check("mrst_a0", a0, 0);
    rst = 1'b0;
    sb.delete();
    model_clear();
    repeat (40) begin
      @(posedge clk); #1;
    end
    check("mrst_a0_late", a0, 0);
    op(4'd0, 1, 0, 3, 1, 1, 32'd0);

    // Shifts
    op(4'd0, 0, 0, 1, 1, 1, 32'h8000_0000);
    op(4'd7, 1, 0, 11, 1, 1, 32'd4);
    op(4'd6, 1, 0, 11, 1, 1, 32'd4);
    op(4'd7, 1, 0, 11, 1, 1, 32'd36);
    op(4'd5, 1, 0, 11, 1, 1, 32'd33);
    drain();

    // Divide codes
    op(4'd0, 0, 0, 1, 1, 1, 32'd100);
    op(4'd0, 0, 0, 2, 1, 1, 32'd7);
`ifdef ALU_EXEC_DIV_EN
    op(4'd11, 1, 2, 10, 1, 0, 32'd0);
    op(4'd12, 1, 2, 11, 1, 0, 32'd0);
    op(4'd11, 1, 0, 12, 1, 0, 32'd0);
    op(4'd12, 1, 0, 13, 1, 0, 32'd0);
    drain();
    check("a0_divu", a0, 32'd14);
`else
    op(4'd11, 1, 2, 10, 1, 0, 32'd0);
    check("divu_ready", ready, 1);
    check("a0_divu_off", a0, 32'd0);
`endif
    drain();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
Parametrised multi-cycle execute block for the CPU datapath. It combines the register file, the operand-2 mux (register or immediate) and an extended ALU.
- Single-cycle integer ops: writeback on the accepting edge.
- Iterative shift-add multiplier: occupies the block for DATA_WIDTH cycles, with a valid/ready handshake toward the control unit.
- a0 is exported for test observation.

Parameters:
REG_FILE_ADDR_WIDTH  5   register address width; 2^N registers
DATA_WIDTH           32  datapath width; must be a power of 2, at least 8
A0_INDEX             10  register exported on a0

Ports:
clk       in   1                    clock, rising edge
rst       in   1                    synchronous, active-high reset
valid_in  in   1                    op request this cycle
ready     out  1                    block can accept an op (IDLE)
AD1       in   REG_FILE_ADDR_WIDTH  source register 1
AD2       in   REG_FILE_ADDR_WIDTH  source register 2
AD3       in   REG_FILE_ADDR_WIDTH  destination register
WE3       in   1                    write result to AD3
ALUsrc    in   1                    0: op2=RD2, 1: op2=ImmOp
ALUctrl   in   4                    operation select
ImmOp     in   DATA_WIDTH           immediate operand
EQ        out  1                    registered RD1==op2 of last accepted op
result    out  DATA_WIDTH           registered result of last completed op
done      out  1                    one-cycle pulse: result/writeback completed
a0        out  DATA_WIDTH           register A0_INDEX, combinational read

Behaviour:
- Reset (clk and rst are the only clocking signals; reset is synchronous and active-high):
  - All registers cleared to 0; state=IDLE; EQ=0; result=0; done=0; ready=1 the cycle after reset.
  - Reset mid-multiply: abort, no writeback, no done.
- Register file: asynchronous reads; register 0 reads 0 and writes to it are dropped; writes on the rising edge.
- Accept: valid_in && ready at a rising edge. valid_in while busy is ignored (not queued). ready = (state==IDLE), combinational from state.
- On accept, EQ <= (RD1 == op2) for every op.
- ALUctrl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount = op2[log2(DATA_WIDTH)-1:0]
  - 8 SLT (signed), 9 SLTU; result 1 or 0
  - 10 MUL: low DATA_WIDTH bits of product
  - 11 DIVU, 12 REMU: see Optional Feature
  - 13-15: result 0
- Arithmetic is modulo 2^DATA_WIDTH; no overflow flag.
- States: IDLE, MUL_RUN (plus DIV_RUN under the macro).
- IDLE, single-cycle op accepted:
  - On the accepting edge: reg[AD3] <= value if WE3; result <= value.
  - Next cycle: done=1.
  - Back-to-back accepts allowed every cycle. A read of AD3 in the following cycle sees the new value.
- IDLE, MUL accepted:
  - Latch multiplicand=RD1, multiplier=op2, AD3, WE3; clear accumulator; cnt=0; state -> MUL_RUN.
- MUL_RUN:
  - Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
  - On the edge where cnt reaches DATA_WIDTH-1 (the DATA_WIDTH-th step): writeback and result update with the final acc (latched AD3/WE3); state -> IDLE; done=1 next cycle.
  - ready=0 for exactly DATA_WIDTH cycles after accept.
- Register inputs AD1/AD2/ImmOp may change during MUL_RUN without effect.

Optional Feature:
- Macro: ALU_EXEC_DIV_EN.
- Defined: ops 11/12 run a restoring unsigned divider in state DIV_RUN, DATA_WIDTH cycles, same handshake and writeback timing as MUL.
  - Divide by zero: DIVU result = all ones; REMU result = dividend.
- Undefined: ops 11/12 behave as codes 13-15 (single-cycle, result 0). No DIV_RUN state or divider logic is present.

Test Plan:
- Reset then ADDI: WE3=1, AD1=0, ALUsrc=1, ImmOp=5, AD3=10, ALUctrl=0 -> a0=5 the next cycle; done pulse; EQ=0.
- Back-to-back ops, x1=7, x2=7:
  - SUB AD1=1, AD2=2, AD3=3 -> x3=0, EQ=1.
  - Next cycle SLT x3<x1 into x4 -> x4=1.
  - Write to AD3=0 -> x0 stays 0.
- MUL: x1=0xFFFF_FFFF, x2=3, AD3=10 -> ready low exactly 32 cycles; a0=0xFFFF_FFFD after completion; done single pulse.
  - valid_in asserted during busy is ignored.
- Reset mid-MUL at cycle 10 -> no write to AD3; ready=1, done=0 the cycle after reset; all regs 0.
- Shifts/SRA: x1=0x8000_0000, ImmOp=4, SRA -> 0xF800_0000; SRL -> 0x0800_0000; shift amount 36 behaves as 4.
- With ALU_EXEC_DIV_EN:
  - DIVU 100/7=14, REMU=2.
  - DIVU by 0 -> 0xFFFF_FFFF.
  - Without the macro, DIVU writes 0 in a single cycle.
